// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the FND scan path: state encoding, blanked
// commons pattern, display geometry and small combinational helpers.
package fnd_pkg;

    typedef enum logic [1:0] {
        S_PAGE0 = 2'd0,
        S_PAGE1 = 2'd1,
        S_BLANK = 2'd2
    } fnd_state_e;

    localparam logic [3:0] FND_OFF = 4'b1111;
    localparam int         DIGITS  = 4;
    localparam int         PAGES   = 2;

    // Active-low one-hot common for the given digit index.
    function automatic logic [3:0] digit_com(input logic [1:0] digit);
        return ~(4'b0001 << digit);
    endfunction

    // Counter width for a modulus of n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fnd_scan_controller_tick_divider.sv
// Free-running prescaler: counts 0..DIV-1 and emits a registered one-cycle
// tick while the count sits at DIV-1.
module tick_divider
    import fnd_pkg::*;
#(
    parameter int DIV = 100_000
) (
    input  logic i_clk,
    input  logic i_reset_n,
    output logic o_tick
);

    localparam int            CW      = cnt_width(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;

    // Next count with wrap at DIV-1.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Tick is registered from the next count so it is aligned with cnt_q == DIV-1.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == CNT_MAX);
        end
    end

    assign o_tick = tick_q;

endmodule

// File: rtl/fnd_scan_controller.sv
// 4-digit, 2-page FND scan sequencer: drives the 8:1 nibble mux select and the
// active-low digit commons, switching pages only on frame boundaries.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV    = 100_000,
    parameter int AUTO_FRAMES = 3000
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_page_btn,
    input  logic       i_auto_en,
    input  logic       i_blank,
    output logic [2:0] o_sel,
    output logic [3:0] o_fnd_com,
    output logic       o_page,
    output logic       o_scan_tick
);

    localparam int            FW        = cnt_width(AUTO_FRAMES);
    localparam logic [FW-1:0] FRAME_MAX = FW'(AUTO_FRAMES - 1);

    logic          scan_tick_s;
    logic          boundary_s;
    logic          manual_s;
    logic          auto_req_s;
    fnd_state_e    page_state_s;

    fnd_state_e    state_q, state_d;
    logic [1:0]    digit_q, digit_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          pend_q,  pend_d;
    logic          page_q,  page_d;
    logic [3:0]    com_q;

    tick_divider #(
        .DIV (SCAN_DIV)
    ) u_tick_divider (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .o_tick    (scan_tick_s)
    );

    // Request arbitration and counter next-state; a button pulse on the
    // boundary cycle itself is folded into that boundary's decision.
    always_comb begin
        boundary_s = scan_tick_s && (digit_q == 2'd3);
        manual_s   = pend_q | i_page_btn;
        auto_req_s = boundary_s && i_auto_en && (frame_q == FRAME_MAX);
        digit_d    = scan_tick_s ? (digit_q + 2'd1) : digit_q;

        if (boundary_s) begin
            pend_d = 1'b0;
            page_d = (manual_s || auto_req_s) ? ~page_q : page_q;
        end else begin
            pend_d = manual_s;
            page_d = page_q;
        end

        if (!i_auto_en) begin
            frame_d = '0;
        end else if (boundary_s) begin
            frame_d = (manual_s || (frame_q == FRAME_MAX)) ? '0 : (frame_q + FW'(1));
        end else begin
            frame_d = frame_q;
        end

        page_state_s = page_d ? S_PAGE1 : S_PAGE0;
        case (state_q)
            S_PAGE0: state_d = i_blank ? S_BLANK : page_state_s;
            S_PAGE1: state_d = i_blank ? S_BLANK : page_state_s;
            S_BLANK: state_d = i_blank ? S_BLANK : page_state_s;
            default: state_d = S_BLANK;
        endcase
    end

    // FSM, scan counters and registered outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_PAGE0;
            digit_q <= 2'd0;
            frame_q <= '0;
            pend_q  <= 1'b0;
            page_q  <= 1'b0;
            com_q   <= FND_OFF;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            frame_q <= frame_d;
            pend_q  <= pend_d;
            page_q  <= page_d;
            com_q   <= (state_d == S_BLANK) ? FND_OFF : digit_com(digit_d);
        end
    end

    assign o_sel       = {page_q, digit_q};
    assign o_fnd_com   = com_q;
    assign o_page      = page_q;
    assign o_scan_tick = scan_tick_s;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller with SCAN_DIV=4, AUTO_FRAMES=2.
// k counts rising edges since reset release; outputs are sampled on the falling edge.
module tb_fnd_scan_controller;

    logic       i_clk = 1'b0;
    logic       i_reset_n;
    logic       i_page_btn;
    logic       i_auto_en;
    logic       i_blank;
    logic [2:0] o_sel;
    logic [3:0] o_fnd_com;
    logic       o_page;
    logic       o_scan_tick;

    int n_checks = 0;
    int n_errors = 0;
    int k = 0;

    fnd_scan_controller #(
        .SCAN_DIV    (4),
        .AUTO_FRAMES (2)
    ) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_page_btn  (i_page_btn),
        .i_auto_en   (i_auto_en),
        .i_blank     (i_blank),
        .o_sel       (o_sel),
        .o_fnd_com   (o_fnd_com),
        .o_page      (o_page),
        .o_scan_tick (o_scan_tick)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        k++;
        @(negedge i_clk);
    endtask

    task automatic run_to(input int t);
        while (k < t) cyc();
    endtask

    // Button high for exactly the next rising edge (edge k+1).
    task automatic pulse_btn();
        i_page_btn = 1'b1;
        cyc();
        i_page_btn = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_reset_n = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        k = 0;
    endtask

    // Digit after edge k is (k/4)%4: first tick is seen after edge 3, digit moves at edge 4.
    function automatic logic [2:0] esel(input int kk, input logic pg);
        logic [1:0] d;
        d = 2'((kk / 4) % 4);
        return {pg, d};
    endfunction

    function automatic logic [3:0] ecom(input int kk);
        logic [1:0] d;
        d = 2'((kk / 4) % 4);
        return ~(4'b0001 << d);
    endfunction

    task automatic check_pos(input string tag, input logic pg);
        check_val($sformatf("%s_sel_k%0d", tag, k), 32'(o_sel), 32'(esel(k, pg)));
        check_val($sformatf("%s_page_k%0d", tag, k), 32'(o_page), 32'(pg));
        check_val($sformatf("%s_com_k%0d", tag, k), 32'(o_fnd_com), 32'(ecom(k)));
    endtask

    task automatic check_reset_outs(input string tag);
        check_val({tag, "_sel"},  32'(o_sel),       32'd0);
        check_val({tag, "_com"},  32'(o_fnd_com),   32'hF);
        check_val({tag, "_page"}, 32'(o_page),      32'd0);
        check_val({tag, "_tick"}, 32'(o_scan_tick), 32'd0);
    endtask

    initial begin
        i_reset_n  = 1'b0;
        i_page_btn = 1'b0;
        i_auto_en  = 1'b0;
        i_blank    = 1'b0;

        // 1: reset state, then plain scanning
        repeat (2) @(negedge i_clk);
        check_reset_outs("rst");
        i_reset_n = 1'b1;
        k = 0;
        for (int j = 1; j <= 20; j++) begin
            cyc();
            check_pos("scan", 1'b0);
            check_val($sformatf("scan_tick_k%0d", k), 32'(o_scan_tick), 32'((k % 4) == 3));
        end

        // 2: button during digit 1 takes effect at the next frame boundary
        pulse_btn();
        run_to(31); check_pos("btn", 1'b0);
        run_to(32); check_pos("btn", 1'b1);
        run_to(36); check_pos("btn", 1'b1);
        run_to(40); check_pos("btn", 1'b1);
        run_to(44); check_pos("btn", 1'b1);

        // 3: two presses in one frame give one toggle; a later press toggles back
        do_reset();
        run_to(4);  pulse_btn();
        run_to(9);  pulse_btn();
        run_to(16); check_pos("dbl", 1'b1);
        run_to(32); check_pos("dbl", 1'b1);
        run_to(35); pulse_btn();
        run_to(47); check_pos("dbl", 1'b1);
        run_to(48); check_pos("dbl", 1'b0);
        run_to(63); pulse_btn();
        check_pos("edgebtn", 1'b1);

        // 4: auto rotation every 2 frames, button coinciding with an auto toggle
        i_auto_en = 1'b1;
        do_reset();
        run_to(31);  check_pos("auto", 1'b0);
        run_to(32);  check_pos("auto", 1'b1);
        run_to(63);  check_pos("auto", 1'b1);
        run_to(64);  check_pos("auto", 1'b0);
        run_to(95);  pulse_btn();
        check_pos("auto_btn", 1'b1);
        run_to(112); check_pos("auto_btn", 1'b1);
        run_to(127); check_pos("auto_btn", 1'b1);
        run_to(128); check_pos("auto_btn", 1'b0);

        // 4b: a manual toggle restarts the auto frame count
        do_reset();
        run_to(4);  pulse_btn();
        run_to(16); check_pos("frst", 1'b1);
        run_to(32); check_pos("frst", 1'b1);
        run_to(48); check_pos("frst", 1'b0);
        i_auto_en = 1'b0;

        // 5: blanking mid-frame; scanning and page requests keep running
        do_reset();
        run_to(5);
        i_blank = 1'b1;
        cyc();
        check_val("blank_com_k6", 32'(o_fnd_com), 32'hF);
        check_val("blank_sel_k6", 32'(o_sel), 32'(esel(k, 1'b0)));
        pulse_btn();
        run_to(8);
        check_val("blank_com_k8", 32'(o_fnd_com), 32'hF);
        check_val("blank_sel_k8", 32'(o_sel), 32'(esel(k, 1'b0)));
        run_to(15);
        check_val("blank_com_k15", 32'(o_fnd_com), 32'hF);
        check_val("blank_sel_k15", 32'(o_sel), 32'(esel(k, 1'b0)));
        i_blank = 1'b0;
        cyc();
        check_pos("unblank", 1'b1);
        run_to(20); check_pos("unblank", 1'b1);

        // 6: asynchronous reset with a request pending discards it
        do_reset();
        run_to(2); pulse_btn();
        run_to(11);
        check_pos("pre_rst", 1'b0);
        check_val("pre_rst_tick", 32'(o_scan_tick), 32'd1);
        i_reset_n = 1'b0;
        #1;
        check_reset_outs("async_rst");
        @(negedge i_clk);
        i_reset_n = 1'b1;
        k = 0;
        run_to(16); check_pos("post_rst", 1'b0);
        run_to(20); check_pos("post_rst", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
